// File: rtl/prog_loader.sv
// Byte-stream program loader: fills instruction memory from a counted,
// XOR-checksummed stream, then releases the CPU from reset.
module prog_loader #(
  parameter int IM_DEPTH = 256,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_rst,
  input  logic          halt,
  output logic          halted,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DATA, CSUM, RUN, HALTED, ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(IM_DEPTH);

  state_t      state, next;
  logic [7:0]  cnt_hi;
  logic [15:0] count;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic        xfer;
  logic [16:0] n_rx;
  logic        last_word;

  assign xfer      = in_valid & in_ready;
  assign n_rx      = {1'b0, cnt_hi, in_data};
  assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, count};

  always_ff @(posedge clk) begin
    if (rst) state <= CNT_HI;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    halted   = 1'b0;
    load_err = 1'b0;
    unique case (state)
      CNT_HI: begin
        in_ready = 1'b1;
        if (xfer) next = CNT_LO;
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (n_rx > DEPTH)       next = ERR;
          else if (n_rx == 17'd0) next = CSUM;
          else                    next = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (xfer && byte_idx == 2'd3 && last_word) next = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (xfer) next = (csum == in_data) ? RUN : ERR;
      end
      RUN: begin
        cpu_rst = 1'b0;
        if (halt) next = HALTED;
      end
      HALTED: begin
        cpu_rst = 1'b0;
        halted  = 1'b1;
      end
      ERR: load_err = 1'b1;
      default: next = CNT_HI;
    endcase
  end

  // Word write is registered one cycle behind its last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi       <= '0;
      count        <= '0;
      csum         <= '0;
      byte_idx     <= '0;
      shift        <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      words_loaded <= '0;
    end else begin
      im_we <= 1'b0;
      if (xfer && state != CSUM) csum <= csum ^ in_data;
      if (xfer && state == CNT_HI) cnt_hi <= in_data;
      if (xfer && state == CNT_LO) count <= {cnt_hi, in_data};
      if (xfer && state == DATA) begin
        byte_idx <= byte_idx + 2'd1;
        shift    <= {shift[15:0], in_data};
        if (byte_idx == 2'd3) begin
          im_we        <= 1'b1;
          im_wdata     <= {shift, in_data};
          im_addr      <= words_loaded[AW-1:0];
          words_loaded <= words_loaded + 1'b1;
        end
      end
    end
  end

endmodule
